// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with grant hold across fixed-length bursts and locked transfers.
// Optional build macro ARB_STATS_EN adds per-master grant and max-wait statistics with an end-of-run report.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK,
  output logic                   burst_busy
);

  localparam logic [1:0]             HTRANS_NSEQ = 2'b10;
  localparam logic [1:0]             HTRANS_SEQ  = 2'b11;
  localparam logic [MW-1:0]          DEF_IDX     = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic is_fixed_burst(input logic [2:0] hburst);
    case (hburst)
      3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111: is_fixed_burst = 1'b1;
      default:                                        is_fixed_burst = 1'b0;
    endcase
  endfunction

  // Remaining beats after the NON_SEQ beat of a fixed burst.
  function automatic logic [3:0] burst_reload(input logic [2:0] hburst);
    case (hburst)
      3'b010, 3'b011: burst_reload = 4'd3;
      3'b100, 3'b101: burst_reload = 4'd7;
      3'b110, 3'b111: burst_reload = 4'd15;
      default:        burst_reload = 4'd0;
    endcase
  endfunction

  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [MW-1:0] idx);
    idx_to_onehot      = {NUM_MASTERS{1'b0}};
    idx_to_onehot[idx] = 1'b1;
  endfunction

  function automatic logic [MW-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    onehot_to_idx = DEF_IDX;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) begin
        onehot_to_idx = MW'(i);
      end else begin
        onehot_to_idx = onehot_to_idx;
      end
    end
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic                   burst_busy_q, burst_busy_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;

  logic [MW-1:0] win_idx;
  logic          win_found;
  logic [MW-1:0] cand;
  logic [MW-1:0] grant_idx;
  logic          start_fixed;
  logic          seq_ready;
  logic          nseq_ready;
  logic          err_first;

  assign start_fixed = (HTRANS == HTRANS_NSEQ) && HREADY && is_fixed_burst(HBURST);
  assign seq_ready   = (HTRANS == HTRANS_SEQ) && HREADY;
  assign nseq_ready  = (HTRANS == HTRANS_NSEQ) && HREADY;
  assign err_first   = HRESP && !HREADY;

  // Round-robin search starting one past the last winner; idle bus falls back to the default master.
  always_comb begin
    win_idx   = DEF_IDX;
    win_found = 1'b0;
    cand      = {MW{1'b0}};
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(rr_ptr_q) + i) % NUM_MASTERS);
      if (!win_found && HBUSREQ[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end else begin
        win_idx = win_idx;
      end
    end
  end

  // Arbitration FSM: grant, burst beat counting, lock hold and error abort.
  always_comb begin
    state_d      = state_q;
    hgrant_d     = hgrant_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    burst_busy_d = burst_busy_q;
    case (state_q)
      ST_ARB: begin
        if (HLOCK[hmaster_q] && HBUSREQ[hmaster_q]) begin
          state_d      = ST_LOCKED;
          hgrant_d     = idx_to_onehot(hmaster_q);
          beat_cnt_d   = 4'd0;
          burst_busy_d = 1'b0;
        end else if (start_fixed) begin
          state_d      = ST_BURST;
          hgrant_d     = idx_to_onehot(hmaster_q);
          beat_cnt_d   = burst_reload(HBURST);
          burst_busy_d = 1'b1;
        end else begin
          hgrant_d     = idx_to_onehot(win_idx);
          rr_ptr_d     = win_idx;
          beat_cnt_d   = 4'd0;
          burst_busy_d = 1'b0;
        end
      end
      ST_BURST: begin
        if (err_first) begin
          state_d      = ST_ARB;
          beat_cnt_d   = 4'd0;
          burst_busy_d = 1'b0;
        end else if (seq_ready) begin
          // Hand the grant over on the last beat so the next owner is ready for its address phase.
          if (beat_cnt_q == 4'd1) begin
            state_d      = ST_ARB;
            hgrant_d     = idx_to_onehot(win_idx);
            rr_ptr_d     = win_idx;
            beat_cnt_d   = 4'd0;
            burst_busy_d = 1'b0;
          end else if (beat_cnt_q != 4'd0) begin
            beat_cnt_d = beat_cnt_q - 4'd1;
          end else begin
            state_d      = ST_ARB;
            burst_busy_d = 1'b0;
          end
        end else if (nseq_ready) begin
          if (is_fixed_burst(HBURST)) begin
            beat_cnt_d = burst_reload(HBURST);
          end else begin
            state_d      = ST_ARB;
            beat_cnt_d   = 4'd0;
            burst_busy_d = 1'b0;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      ST_LOCKED: begin
        if (err_first) begin
          state_d      = ST_ARB;
          beat_cnt_d   = 4'd0;
          burst_busy_d = 1'b0;
        end else if (!HLOCK[hmaster_q] && HREADY) begin
          state_d  = ST_ARB;
          hgrant_d = idx_to_onehot(win_idx);
          rr_ptr_d = win_idx;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d      = ST_ARB;
        hgrant_d     = DEF_GRANT;
        rr_ptr_d     = DEF_IDX;
        beat_cnt_d   = 4'd0;
        burst_busy_d = 1'b0;
      end
    endcase
  end

  // Address-phase ownership follows the grant only when the current transfer completes.
  always_comb begin
    grant_idx = onehot_to_idx(hgrant_q);
    if (HREADY) begin
      hmaster_d   = grant_idx;
      hmastlock_d = HLOCK[grant_idx];
    end else begin
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
    end
  end

  // State and output registers.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ARB;
      hgrant_q     <= DEF_GRANT;
      hmaster_q    <= DEF_IDX;
      hmastlock_q  <= 1'b0;
      burst_busy_q <= 1'b0;
      beat_cnt_q   <= 4'd0;
      rr_ptr_q     <= DEF_IDX;
    end else begin
      state_q      <= state_d;
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmastlock_q  <= hmastlock_d;
      burst_busy_q <= burst_busy_d;
      beat_cnt_q   <= beat_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign HGRANT     = hgrant_q;
  assign HMASTER    = hmaster_q;
  assign HMASTLOCK  = hmastlock_q;
  assign burst_busy = burst_busy_q;

`ifdef ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_MASTERS];
  logic [31:0] grant_cnt_d [NUM_MASTERS];
  logic [31:0] wait_cnt_q  [NUM_MASTERS];
  logic [31:0] wait_cnt_d  [NUM_MASTERS];
  logic [31:0] max_wait_q  [NUM_MASTERS];
  logic [31:0] max_wait_d  [NUM_MASTERS];

  // Per-master handover counts and longest request-to-grant wait.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      wait_cnt_d[i]  = wait_cnt_q[i];
      max_wait_d[i]  = max_wait_q[i];
      if (HREADY && (hmaster_d == MW'(i)) && (hmaster_q != MW'(i))) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end else begin
        grant_cnt_d[i] = grant_cnt_q[i];
      end
      if (HBUSREQ[i] && !hgrant_q[i]) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 32'd1;
      end else begin
        wait_cnt_d[i] = 32'd0;
      end
      if (wait_cnt_d[i] > max_wait_q[i]) begin
        max_wait_d[i] = wait_cnt_d[i];
      end else begin
        max_wait_d[i] = max_wait_q[i];
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_cnt_q[i] <= 32'd0;
        wait_cnt_q[i]  <= 32'd0;
        max_wait_q[i]  <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        wait_cnt_q[i]  <= wait_cnt_d[i];
        max_wait_q[i]  <= max_wait_d[i];
      end
    end
  end

  final begin
    $display("master  grants      max_wait");
    for (int i = 0; i < NUM_MASTERS; i++) begin
      $display("%6d  %10d  %8d", i, grant_cnt_q[i], max_wait_q[i]);
    end
  end
`endif

endmodule
